// File: rtl/instruction_register.sv
// Instruction register: latches an instruction from the CPU bus, exposes its opcode,
// drives the operand back onto the bus, counts loads and latches a sticky halt.
module instruction_register #(
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_in,
  input  logic       li,
  input  logic       eo,
  input  logic       clr,
  output logic [3:0] opcode,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       ir_valid,
  output logic       halted,
  output logic [7:0] instr_count
);

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] LOADED = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state;
  logic [7:0] ir;
  logic [7:0] cnt;
  logic       load;

  assign load = li && (state != HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ir    <= 8'h00;
      cnt   <= 8'h00;
    end else if (clr) begin
      // Clear wipes the instruction but keeps the lifetime load count.
      state <= EMPTY;
      ir    <= 8'h00;
    end else if (load) begin
      ir    <= bus_in;
      cnt   <= (cnt == 8'hFF) ? 8'hFF : cnt + 8'h01;
      state <= (bus_in[7:4] == HLT_OPCODE) ? HALTED : LOADED;
    end
  end

  assign opcode      = ir[7:4];
  assign bus_oe      = eo;
  assign bus_out     = eo ? {4'h0, ir[3:0]} : 8'h00;
  assign ir_valid    = (state != EMPTY);
  assign halted      = (state == HALTED);
  assign instr_count = cnt;

endmodule
